// File: rtl/sync_updown_counter.sv
// Synchronous modulo-MOD up/down counter with load clamp, terminal count and wrap pulse.
// Define SYNC_COUNTER_SATURATE_EN to saturate at the range limits instead of wrapping.
module sync_updown_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  // Next-state: load beats count beats hold; counts past either limit wrap or saturate
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_val > MAX_VAL) begin
        count_d    = MAX_VAL;
        load_err_d = 1'b1;
      end else begin
        count_d    = load_val;
      end
    end else if (en) begin
      if (up) begin
        // Values above MAX_VAL can only come from corruption; treat them as terminal
        if (count_q >= MAX_VAL) begin
`ifdef SYNC_COUNTER_SATURATE_EN
          count_d = MAX_VAL;
`else
          count_d = ZERO_VAL;
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = count_q + ONE_VAL;
        end
      end else begin
        if (count_q == ZERO_VAL) begin
`ifdef SYNC_COUNTER_SATURATE_EN
          count_d = ZERO_VAL;
`else
          count_d = MAX_VAL;
          wrap_d  = 1'b1;
`endif
        end else if (count_q > MAX_VAL) begin
          count_d = MAX_VAL;
`ifdef SYNC_COUNTER_SATURATE_EN
          wrap_d  = 1'b0;
`else
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = count_q - ONE_VAL;
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // State and pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign zero     = (count_q == ZERO_VAL);
  assign tc       = en & ~load & ((up & (count_q == MAX_VAL)) | (~up & (count_q == ZERO_VAL)));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Scoreboard bench for sync_updown_counter (WIDTH=4, MOD=10); expectations follow the
// saturating variant when SYNC_COUNTER_SATURATE_EN is defined.
module tb_sync_updown_counter;
  localparam int W = 4;
  localparam int M = 10;
  localparam logic [W-1:0] MAXV = W'(M - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         tc, wrap, load_err, zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic         wrap;
    logic         lerr;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_q = '0;
  logic         exp_tc = 1'b0;
  int           checks = 0;
  int           failures = 0;

  sync_updown_counter #(.WIDTH(W), .MOD(M)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q), .tc(tc), .wrap(wrap), .load_err(load_err), .zero(zero)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus; compute expected tc now and push the post-edge state
  task automatic drive(input logic e, input logic u, input logic l, input logic [W-1:0] lv);
    exp_t x;
    en = e; up = u; load = l; load_val = lv;
    exp_tc = e & ~l & ((u & (m_q == MAXV)) | (~u & (m_q == '0)));
    x.q = m_q; x.wrap = 1'b0; x.lerr = 1'b0;
    if (l) begin
      if (lv >= W'(M)) begin x.q = MAXV; x.lerr = 1'b1; end
      else x.q = lv;
    end else if (e) begin
      if (u) begin
        if (m_q == MAXV) begin
`ifdef SYNC_COUNTER_SATURATE_EN
          x.q = MAXV;
`else
          x.q = '0; x.wrap = 1'b1;
`endif
        end else x.q = m_q + ONE;
      end else begin
        if (m_q == '0) begin
`ifdef SYNC_COUNTER_SATURATE_EN
          x.q = '0;
`else
          x.q = MAXV; x.wrap = 1'b1;
`endif
        end else x.q = m_q - ONE;
      end
    end
    m_q = x.q;
    sb.push_back(x);
  endtask

  task automatic test_reset_initial();
    reset_n = 1'b0;
    #2;
    checks++;
    if ({q, zero, wrap, load_err, tc} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_initial: got q=%0d zero=%b wrap=%b load_err=%b tc=%b expected q=0 zero=1 wrap=0 load_err=0 tc=0",
               q, zero, wrap, load_err, tc);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    m_q = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_up_wrap();
    exp_t x;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 1'b1, 4'd0);
      else        drive(1'b1, 1'b1, 1'b0, 4'd0);
      #1; checks++;
      if (tc !== exp_tc) begin
        failures++; $display("FAIL up_wrap tc step %0d: got %b expected %b", i, tc, exp_tc);
      end
      @(posedge clk); #1;
      x = sb.pop_front(); checks++;
      if ({q, wrap, load_err, zero} !== {x.q, x.wrap, x.lerr, (x.q == '0)}) begin
        failures++;
        $display("FAIL up_wrap state step %0d: got q=%0d wrap=%b load_err=%b zero=%b expected q=%0d wrap=%b load_err=%b",
                 i, q, wrap, load_err, zero, x.q, x.wrap, x.lerr);
      end
    end
  endtask

  task automatic test_down_wrap();
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1'b0, 1'b0, 1'b1, 4'd0);
      else        drive(1'b1, 1'b0, 1'b0, 4'd0);
      #1; checks++;
      if (tc !== exp_tc) begin
        failures++; $display("FAIL down_wrap tc step %0d: got %b expected %b", i, tc, exp_tc);
      end
      @(posedge clk); #1;
      x = sb.pop_front(); checks++;
      if ({q, wrap, load_err, zero} !== {x.q, x.wrap, x.lerr, (x.q == '0)}) begin
        failures++;
        $display("FAIL down_wrap state step %0d: got q=%0d wrap=%b load_err=%b zero=%b expected q=%0d wrap=%b load_err=%b",
                 i, q, wrap, load_err, zero, x.q, x.wrap, x.lerr);
      end
    end
  endtask

  task automatic test_load();
    exp_t x;
    logic [W-1:0] vals [5] = '{4'd5, 4'd12, 4'd9, 4'd15, 4'd10};
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(1'b1, i[0], 1'b1, vals[i]);
      else       drive(1'b0, 1'b1, 1'b0, 4'd0);
      #1; checks++;
      if (tc !== exp_tc) begin
        failures++; $display("FAIL load tc step %0d: got %b expected %b", i, tc, exp_tc);
      end
      @(posedge clk); #1;
      x = sb.pop_front(); checks++;
      if ({q, wrap, load_err, zero} !== {x.q, x.wrap, x.lerr, (x.q == '0)}) begin
        failures++;
        $display("FAIL load state step %0d: got q=%0d wrap=%b load_err=%b zero=%b expected q=%0d wrap=%b load_err=%b",
                 i, q, wrap, load_err, zero, x.q, x.wrap, x.lerr);
      end
    end
  endtask

  task automatic test_dir_change();
    exp_t x;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       drive(1'b0, 1'b1, 1'b1, 4'd3);
        1, 2:    drive(1'b1, 1'b1, 1'b0, 4'd0);
        3, 4:    drive(1'b1, 1'b0, 1'b0, 4'd0);
        default: drive(1'b0, 1'b1, 1'b0, 4'd0);
      endcase
      #1; checks++;
      if (tc !== exp_tc) begin
        failures++; $display("FAIL dir_change tc step %0d: got %b expected %b", i, tc, exp_tc);
      end
      @(posedge clk); #1;
      x = sb.pop_front(); checks++;
      if ({q, wrap, load_err, zero} !== {x.q, x.wrap, x.lerr, (x.q == '0)}) begin
        failures++;
        $display("FAIL dir_change state step %0d: got q=%0d wrap=%b load_err=%b zero=%b expected q=%0d wrap=%b load_err=%b",
                 i, q, wrap, load_err, zero, x.q, x.wrap, x.lerr);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1'b0, 1'b0, 1'b1, 4'd9);
      else        drive(1'b1, i[0], 1'b0, 4'd0);
      #1; checks++;
      if (tc !== exp_tc) begin
        failures++; $display("FAIL back_to_back tc step %0d: got %b expected %b", i, tc, exp_tc);
      end
      @(posedge clk); #1;
      x = sb.pop_front(); checks++;
      if ({q, wrap, load_err, zero} !== {x.q, x.wrap, x.lerr, (x.q == '0)}) begin
        failures++;
        $display("FAIL back_to_back state step %0d: got q=%0d wrap=%b load_err=%b zero=%b expected q=%0d wrap=%b load_err=%b",
                 i, q, wrap, load_err, zero, x.q, x.wrap, x.lerr);
      end
    end
  endtask

  task automatic test_limits();
    exp_t x;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:          drive(1'b0, 1'b1, 1'b1, 4'd8);
        1, 2, 3:    drive(1'b1, 1'b1, 1'b0, 4'd0);
        4:          drive(1'b0, 1'b0, 1'b1, 4'd1);
        default:    drive(1'b1, 1'b0, 1'b0, 4'd0);
      endcase
      #1; checks++;
      if (tc !== exp_tc) begin
        failures++; $display("FAIL limits tc step %0d: got %b expected %b", i, tc, exp_tc);
      end
      @(posedge clk); #1;
      x = sb.pop_front(); checks++;
      if ({q, wrap, load_err, zero} !== {x.q, x.wrap, x.lerr, (x.q == '0)}) begin
        failures++;
        $display("FAIL limits state step %0d: got q=%0d wrap=%b load_err=%b zero=%b expected q=%0d wrap=%b load_err=%b",
                 i, q, wrap, load_err, zero, x.q, x.wrap, x.lerr);
      end
    end
  endtask

  task automatic test_reset_midcount();
    exp_t x;
    drive(1'b0, 1'b1, 1'b1, 4'd9);
    @(posedge clk); #1;
    x = sb.pop_front(); checks++;
    if (q !== x.q) begin
      failures++; $display("FAIL reset_mid preload: got q=%0d expected q=%0d", q, x.q);
    end
    en = 1'b1; up = 1'b1; load = 1'b0;
    #2 reset_n = 1'b0;
    #1; checks++;
    if ({q, zero, wrap, load_err} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid async: got q=%0d zero=%b wrap=%b load_err=%b expected q=0 zero=1 wrap=0 load_err=0",
               q, zero, wrap, load_err);
    end
    m_q = '0;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd0) begin
      failures++; $display("FAIL reset_mid held: got q=%0d expected q=0", q);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    m_q = ONE;
    checks++;
    if ({q, wrap} !== {4'd1, 1'b0}) begin
      failures++; $display("FAIL reset_mid resume: got q=%0d wrap=%b expected q=1 wrap=0", q, wrap);
    end
  endtask

  initial begin
    test_reset_initial();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_dir_change();
    test_back_to_back();
    test_limits();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
